// File: rtl/data_sram_rsp_if.sv
// Requester <-> data SRAM responder bus: request/address handshake plus response strobe.
// master = requester side, slave = memory side.
interface data_sram_rsp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_rsp.sv
// Single-outstanding 32-bit data SRAM with byte-lane writes and a one-cycle response strobe.
// Latency: data_ok exactly D cycles after req&addr_ok, D = RESP_DLY (plus lfsr[2:1] with DATA_SRAM_RSP_RAND_DLY_EN).
// Backpressure: addr_ok only while IDLE; DATA_SRAM_RSP_RAND_DLY_EN also gates it with a free-running LFSR.
module data_sram_rsp #(
    parameter int          MEM_AW    = 10,
    parameter int          RESP_DLY  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic           clk,
    input logic           resetn,
    data_sram_rsp_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              err_q;
    logic [31:0]       rd_q;
    logic [31:0]       mem [0:(1<<MEM_AW)-1];

    logic              hs;
    logic              err_c;
    logic [3:0]        dly;
    logic [MEM_AW-1:0] idx;
    logic              idle_ok;

    assign idx = bus.addr[MEM_AW+1:2];

`ifdef DATA_SRAM_RSP_RAND_DLY_EN
    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign idle_ok = lfsr[0];
    assign dly     = 4'(RESP_DLY) + {2'b00, lfsr[2:1]};
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign idle_ok     = 1'b1;
    assign dly         = 4'(RESP_DLY);
`endif

    logic unused_addr;
    assign unused_addr = ^bus.addr[31:MEM_AW+2];

    assign bus.addr_ok = resetn & (state == IDLE) & idle_ok;
    assign hs          = bus.req & bus.addr_ok;

    always_comb begin
        err_c = 1'b0;
        case (bus.size)
            2'd1:    err_c = bus.addr[0];
            2'd2:    err_c = (bus.addr[1:0] != 2'b00);
            2'd3:    err_c = 1'b1;
            default: err_c = 1'b0;
        endcase
    end

    // Memory is never reset so committed writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (hs && bus.wr && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read word is captured at the handshake; nothing can write it before the response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
            rd_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        err_q <= err_c;
                        rd_q  <= (!bus.wr && !err_c) ? mem[idx] : 32'd0;
                        if (dly == 4'd1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= dly - 4'd2;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_ok = (state == RESP);
    assign bus.rdata   = bus.data_ok ? rd_q  : 32'd0;
    assign bus.err     = bus.data_ok ? err_q : 1'b0;

endmodule
